// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - capture-buffer timestamp constants and the {time, index} word layout
package buffer_pkg;
    localparam int TSTAMP_WIDTH       = 64;
    localparam int SAMPLE_INDEX_WIDTH = 14;
    localparam int TIME_WIDTH         = TSTAMP_WIDTH - SAMPLE_INDEX_WIDTH;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]         time_val;
        logic [SAMPLE_INDEX_WIDTH-1:0] index;
    } tstamp_t;
endpackage

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - receive-path constants shared by the capture blocks
package rx_pkg;
    localparam int DATA_WIDTH = 256;
endpackage

// File: rtl/sample_reconstructor_skid.sv
// rtl/sample_reconstructor_skid.sv - 2-entry registered output skid buffer, full throughput
module sample_reconstructor_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Ready depends only on the skid flag, so upstream sees no combinational path from m_ready_i.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || m_ready_i) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = s_valid_i;
                if (s_valid_i) begin
                    out_data_d = s_data_i;
                end
            end
        end else if (s_valid_i && !skid_valid_q) begin
            skid_data_d  = s_data_i;
            skid_valid_d = 1'b1;
        end
    end

    assign s_ready_o = !skid_valid_q;
    assign m_data_o  = out_data_q;
    assign m_valid_o = out_valid_q;
endmodule

// File: rtl/sample_reconstructor.sv
// rtl/sample_reconstructor.sv - rebuilds a time-contiguous batch stream from segments; SAMPLE_RECONSTRUCTOR_GAP_MARKER_EN selects one-beat gap markers
module sample_reconstructor #(
    parameter int                    DATA_WIDTH         = rx_pkg::DATA_WIDTH,
    parameter int                    TSTAMP_WIDTH       = buffer_pkg::TSTAMP_WIDTH,
    parameter int                    SAMPLE_INDEX_WIDTH = buffer_pkg::SAMPLE_INDEX_WIDTH,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE         = '0
) (
    input  logic                    adc_clk,
    input  logic                    adc_reset,
    input  logic [DATA_WIDTH-1:0]   data_in_data,
    input  logic                    data_in_valid,
    input  logic                    data_in_last,
    output logic                    data_in_ready,
    input  logic [TSTAMP_WIDTH-1:0] tstamp_in_data,
    input  logic                    tstamp_in_valid,
    input  logic                    tstamp_in_last,
    output logic                    tstamp_in_ready,
    output logic [DATA_WIDTH-1:0]   data_out_data,
    output logic                    data_out_valid,
    output logic                    data_out_last,
    input  logic                    data_out_ready,
    output logic                    gap_marker,
    output logic                    error
);
    localparam int SW = SAMPLE_INDEX_WIDTH;
    localparam int TW = TSTAMP_WIDTH - SAMPLE_INDEX_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH_CUR, ST_FETCH_NEXT, ST_DATA, ST_FILL, ST_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cur_time_q, cur_time_d, nxt_time_q, nxt_time_d;
    logic [SW-1:0]   cur_idx_q, cur_idx_d, nxt_idx_q, nxt_idx_d;
    logic            nxt_valid_q, nxt_valid_d, nxt_last_q, nxt_last_d;
    logic [SW-1:0]   batch_cnt_q, batch_cnt_d;
    logic [TW-1:0]   fill_cnt_q, fill_cnt_d;
    logic            error_q, error_d;

    logic [TW-1:0]   ts_time;
    logic [SW-1:0]   ts_idx;
    logic [TW-1:0]   gap;
    logic            seg_end, do_promote;
    logic            push_valid, push_ready, push_last;
    logic [DATA_WIDTH-1:0] push_data;

    assign ts_time = tstamp_in_data[TSTAMP_WIDTH-1:SW];
    assign ts_idx  = tstamp_in_data[SW-1:0];
    assign seg_end = nxt_valid_q && (batch_cnt_q == nxt_idx_q);
    // Both differences wrap in their own field widths; a set MSB means the segments overlap.
    assign gap     = nxt_time_q - (cur_time_q + TW'(nxt_idx_q - cur_idx_q));

    always_ff @(posedge adc_clk or posedge adc_reset) begin
        if (adc_reset) begin
            state_q     <= ST_IDLE;
            cur_time_q  <= '0;
            cur_idx_q   <= '0;
            nxt_time_q  <= '0;
            nxt_idx_q   <= '0;
            nxt_valid_q <= 1'b0;
            nxt_last_q  <= 1'b0;
            batch_cnt_q <= '0;
            fill_cnt_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_time_q  <= cur_time_d;
            cur_idx_q   <= cur_idx_d;
            nxt_time_q  <= nxt_time_d;
            nxt_idx_q   <= nxt_idx_d;
            nxt_valid_q <= nxt_valid_d;
            nxt_last_q  <= nxt_last_d;
            batch_cnt_q <= batch_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cur_time_d      = cur_time_q;
        cur_idx_d       = cur_idx_q;
        nxt_time_d      = nxt_time_q;
        nxt_idx_d       = nxt_idx_q;
        nxt_valid_d     = nxt_valid_q;
        nxt_last_d      = nxt_last_q;
        batch_cnt_d     = batch_cnt_q;
        fill_cnt_d      = fill_cnt_q;
        error_d         = error_q;
        data_in_ready   = 1'b0;
        tstamp_in_ready = 1'b0;
        push_valid      = 1'b0;
        push_data       = data_in_data;
        push_last       = data_in_last;
        do_promote      = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH_CUR;
            ST_FETCH_CUR: begin
                tstamp_in_ready = 1'b1;
                if (tstamp_in_valid) begin
                    cur_time_d  = ts_time;
                    cur_idx_d   = ts_idx;
                    nxt_valid_d = 1'b0;
                    state_d     = tstamp_in_last ? ST_DATA : ST_FETCH_NEXT;
                end
            end
            ST_FETCH_NEXT: begin
                tstamp_in_ready = 1'b1;
                if (tstamp_in_valid) begin
                    nxt_time_d  = ts_time;
                    nxt_idx_d   = ts_idx;
                    nxt_valid_d = 1'b1;
                    nxt_last_d  = tstamp_in_last;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (seg_end) begin
                    if (gap[TW-1]) begin
                        error_d = 1'b1;
                    end
                    if (gap[TW-1] || gap == '0) begin
                        do_promote = 1'b1;
                    end else begin
                        fill_cnt_d = gap;
                        state_d    = ST_FILL;
                    end
                end else begin
                    data_in_ready = push_ready;
                    push_valid    = data_in_valid;
                    if (data_in_valid && push_ready) begin
                        batch_cnt_d = batch_cnt_q + SW'(1);
                        if (data_in_last) begin
                            batch_cnt_d = '0;
                            fill_cnt_d  = '0;
                            nxt_valid_d = 1'b0;
                            // Capture ended before the announced segment: flush any unread timestamps.
                            if (nxt_valid_q) begin
                                error_d = 1'b1;
                                state_d = nxt_last_q ? ST_IDLE : ST_DROP;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
            ST_FILL: begin
                push_valid = 1'b1;
                push_last  = 1'b0;
`ifdef SAMPLE_RECONSTRUCTOR_GAP_MARKER_EN
                push_data = DATA_WIDTH'(fill_cnt_q);
                if (push_ready) begin
                    do_promote = 1'b1;
                end
`else
                push_data = FILL_VALUE;
                if (push_ready) begin
                    fill_cnt_d = fill_cnt_q - TW'(1);
                    if (fill_cnt_q == TW'(1)) begin
                        do_promote = 1'b1;
                    end
                end
`endif
            end
            ST_DROP: begin
                tstamp_in_ready = 1'b1;
                if (tstamp_in_valid && tstamp_in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_promote) begin
            cur_time_d  = nxt_time_q;
            cur_idx_d   = nxt_idx_q;
            nxt_valid_d = 1'b0;
            state_d     = nxt_last_q ? ST_DATA : ST_FETCH_NEXT;
        end
    end

`ifdef SAMPLE_RECONSTRUCTOR_GAP_MARKER_EN
    localparam int PW = DATA_WIDTH + 2;
    logic [PW-1:0] push_pack, pop_pack;
    assign push_pack     = {state_q == ST_FILL, push_last, push_data};
    assign gap_marker    = pop_pack[DATA_WIDTH+1];
`else
    localparam int PW = DATA_WIDTH + 1;
    logic [PW-1:0] push_pack, pop_pack;
    assign push_pack     = {push_last, push_data};
    assign gap_marker    = 1'b0;
`endif
    assign data_out_last = pop_pack[DATA_WIDTH];
    assign data_out_data = pop_pack[DATA_WIDTH-1:0];
    assign error         = error_q;

    sample_reconstructor_skid #(
        .WIDTH(PW)
    ) u_skid (
        .clk_i    (adc_clk),
        .rst_i    (adc_reset),
        .s_data_i (push_pack),
        .s_valid_i(push_valid),
        .s_ready_o(push_ready),
        .m_data_o (pop_pack),
        .m_valid_o(data_out_valid),
        .m_ready_i(data_out_ready)
    );
endmodule

// File: tb/tb_sample_reconstructor.sv
// tb/tb_sample_reconstructor.sv - directed self-checking bench for sample_reconstructor
module tb_sample_reconstructor;
    import buffer_pkg::*;

    localparam int DW = 256;
    localparam int CW = DW + 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [DW-1:0]           din_data = '0;
    logic                    din_valid = 1'b0;
    logic                    din_last = 1'b0;
    logic                    din_ready;
    logic [TSTAMP_WIDTH-1:0] ts_data = '0;
    logic                    ts_valid = 1'b0;
    logic                    ts_last = 1'b0;
    logic                    ts_ready;
    logic [DW-1:0]           dout_data;
    logic                    dout_valid;
    logic                    dout_last;
    logic                    dout_ready = 1'b1;
    logic                    gap_marker;
    logic                    error;

    int total = 0;
    int bad   = 0;
    bit bp_en = 1'b0;
    logic [CW-1:0]           out_q[$];
    logic [CW-1:0]           exp_q[$];
    logic [TSTAMP_WIDTH-1:0] ts_q[$];
    logic                    stalled = 1'b0;
    logic [CW-1:0]           stall_beat = '0;

    always #5 clk = ~clk;

    sample_reconstructor dut (
        .adc_clk        (clk),
        .adc_reset      (rst),
        .data_in_data   (din_data),
        .data_in_valid  (din_valid),
        .data_in_last   (din_last),
        .data_in_ready  (din_ready),
        .tstamp_in_data (ts_data),
        .tstamp_in_valid(ts_valid),
        .tstamp_in_last (ts_last),
        .tstamp_in_ready(ts_ready),
        .data_out_data  (dout_data),
        .data_out_valid (dout_valid),
        .data_out_last  (dout_last),
        .data_out_ready (dout_ready),
        .gap_marker     (gap_marker),
        .error          (error)
    );

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid_held", CW'(dout_valid), CW'(1));
                chk("stall_beat_stable", {gap_marker, dout_last, dout_data}, stall_beat);
            end
            if (dout_valid && dout_ready) begin
                out_q.push_back({gap_marker, dout_last, dout_data});
            end
            stalled    = dout_valid && !dout_ready;
            stall_beat = {gap_marker, dout_last, dout_data};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic [TSTAMP_WIDTH-1:0] mk(input int t, input int i);
        tstamp_t w;
        w.time_val = TIME_WIDTH'(t);
        w.index    = SAMPLE_INDEX_WIDTH'(i);
        return w;
    endfunction

    task automatic handshake(input string tag, input bit is_ts);
        int   n = 0;
        logic seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            seen = is_ts ? ts_ready : din_ready;
        end while (!seen && n < 400);
        @(posedge clk);
        #1;
        chk(tag, CW'(seen), CW'(1));
    endtask

    task automatic send_ts();
        for (int i = 0; i < ts_q.size(); i++) begin
            ts_data  = ts_q[i];
            ts_valid = 1'b1;
            ts_last  = (i == ts_q.size() - 1);
            handshake("ts_accept", 1'b1);
        end
        ts_valid = 1'b0;
        ts_last  = 1'b0;
    endtask

    task automatic send_data(input int n, input int base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            din_data  = DW'(base + i);
            din_valid = 1'b1;
            din_last  = with_last && (i == n - 1);
            handshake("din_accept", 1'b0);
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic exp_data(input int base, input int n, input bit last_final);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, last_final && (i == n - 1), DW'(base + i)});
        end
    endtask

    task automatic exp_gap(input int g);
`ifdef SAMPLE_RECONSTRUCTOR_GAP_MARKER_EN
        exp_q.push_back({1'b1, 1'b0, DW'(g)});
`else
        for (int i = 0; i < g; i++) begin
            exp_q.push_back({1'b0, 1'b0, {DW{1'b0}}});
        end
`endif
    endtask

    task automatic run(input string name, input int n, input int base);
        int            cyc = 0;
        logic          done = 1'b0;
        logic [CW-1:0] tail;
        fork
            send_ts();
            send_data(n, base, 1'b1);
        join
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (out_q.size() > 0) begin
                tail = out_q[out_q.size() - 1];
                done = tail[DW];
            end
        end
        chk({name, "_last_seen"}, CW'(done), CW'(1));
        repeat (4) @(negedge clk);
        chk({name, "_len"}, CW'(out_q.size()), CW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", name, i), out_q[i], exp_q[i]);
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout_valid", CW'(dout_valid), CW'(0));
        chk("rst_dout_last", CW'(dout_last), CW'(0));
        chk("rst_gap_marker", CW'(gap_marker), CW'(0));
        chk("rst_error", CW'(error), CW'(0));
        chk("rst_din_ready", CW'(din_ready), CW'(0));
        chk("rst_ts_ready", CW'(ts_ready), CW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        ts_q.delete(); ts_q.push_back(mk(100, 0)); ts_q.push_back(mk(110, 4));
        exp_data(1, 4, 1'b0); exp_gap(6); exp_data(5, 2, 1'b1);
        run("gap6", 6, 1);
        chk("gap6_error", CW'(error), CW'(0));

        ts_q.delete(); ts_q.push_back(mk(0, 0)); ts_q.push_back(mk(3, 3));
        exp_data(11, 5, 1'b1);
        run("contig", 5, 11);
        chk("contig_error", CW'(error), CW'(0));

        ts_q.delete(); ts_q.push_back(mk(0, 0)); ts_q.push_back(mk(5, 0)); ts_q.push_back(mk(7, 2));
        exp_gap(5); exp_data(21, 4, 1'b1);
        run("empty_seg", 4, 21);
        chk("empty_seg_error", CW'(error), CW'(0));

        bp_en = 1'b1;
        ts_q.delete(); ts_q.push_back(mk(100, 0)); ts_q.push_back(mk(110, 4));
        exp_data(31, 4, 1'b0); exp_gap(6); exp_data(35, 2, 1'b1);
        run("backpressure", 6, 31);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        chk("backpressure_error", CW'(error), CW'(0));

        ts_q.delete(); ts_q.push_back(mk(0, 0)); ts_q.push_back(mk(2, 4));
        exp_data(41, 6, 1'b1);
        run("overlap", 6, 41);
        chk("overlap_error", CW'(error), CW'(1));

        ts_q.delete(); ts_q.push_back(mk(100, 0)); ts_q.push_back(mk(110, 4));
        fork
            send_ts();
            send_data(4, 51, 1'b0);
        join
        cyc = 0;
        while (out_q.size() < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("fill_reached", CW'(out_q.size() >= 5), CW'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("midfill_rst_valid", CW'(dout_valid), CW'(0));
        chk("midfill_rst_last", CW'(dout_last), CW'(0));
        chk("midfill_rst_marker", CW'(gap_marker), CW'(0));
        chk("midfill_rst_error", CW'(error), CW'(0));
        chk("midfill_rst_din_ready", CW'(din_ready), CW'(0));
        chk("midfill_rst_ts_ready", CW'(ts_ready), CW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_q.delete();
        @(negedge clk);
        chk("idle_after_rst", CW'(ts_ready), CW'(0));
        @(negedge clk);
        chk("fetch_cur_after_idle", CW'(ts_ready), CW'(1));
        chk("no_beat_after_rst", CW'(out_q.size()), CW'(0));

        ts_q.delete(); ts_q.push_back(mk(0, 0)); ts_q.push_back(mk(3, 3));
        exp_data(61, 5, 1'b1);
        run("post_rst", 5, 61);
        chk("post_rst_error", CW'(error), CW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
